// File: rtl/arb_pkg.sv
// Shared definitions for the 16-way request arbiter.
//   arb_state_e   : arbiter FSM states (idle / busy)
//   NO_GRANT_CODE : status code reported while no grant is active
//   N_REQ         : number of requesters the design supports
//   rot_right16() : cyclic right rotation used to re-base the priority search
package arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam logic [7:0] NO_GRANT_CODE = 8'hF0;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

  // Result bit j takes vec[(j + amt) mod 16], so position 15 of the result
  // holds vec[amt - 1] and the priority encoder searches downward from there.
  function automatic logic [15:0] rot_right16(input logic [15:0] vec, input logic [3:0] amt);
    logic [31:0] dbl;
    dbl = {vec, vec} >> amt;
    return dbl[15:0];
  endfunction

endpackage

// File: rtl/req_arbiter16_if.sv
// Handshake bundle between the requesters and the arbiter.
//   req           : request vector, bit i = requester i
//   rr_mode       : 0 = fixed priority, 1 = round-robin
//   release_req   : current grantee is done
//   grant         : one-hot grant or all-zero
//   grant_idx     : index of current / last grantee
//   grant_valid   : a grant is active
//   status        : {4'h0, grant_idx} when granted, else 8'hF0
//   timeout_pulse : one-cycle pulse when a grant is revoked by the hold limit
// master = requester side, slave = arbiter side.
interface req_arbiter16_if;

  logic [15:0] req;
  logic        rr_mode;
  logic        release_req;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic [7:0]  status;
  logic        timeout_pulse;

  modport master (
    output req,
    output rr_mode,
    output release_req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  status,
    input  timeout_pulse
  );

  modport slave (
    input  req,
    input  rr_mode,
    input  release_req,
    output grant,
    output grant_idx,
    output grant_valid,
    output status,
    output timeout_pulse
  );

endinterface

// File: rtl/prio_enc16.sv
// Combinational 16-bit priority encoder, highest set bit wins.
//   in_i  : input vector
//   idx_o : index of the highest set bit (0 when none set)
//   any_o : at least one bit of in_i is set
module prio_enc16 (
  input  logic [15:0] in_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Ascending scan: later (higher) hits overwrite earlier ones.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < 16; i++) begin
      if (in_i[i]) begin
        idx_o = 4'(i);
      end
    end
  end

  assign any_o = |in_i;

endmodule

// File: rtl/req_arbiter16.sv
// 16-way sequential arbiter for one shared downstream resource.
// A winner is picked in IDLE (fixed highest-index-first or round-robin),
// registered, and held in BUSY until release, requester withdrawal or the
// hold limit. Every grant is followed by exactly one idle cycle.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : request/grant bundle (slave side), see req_arbiter16_if
// Parameters:
//   NReq    : number of requesters, must be 16
//   MaxHold : max consecutive grant cycles, 0 disables the timeout
//   HoldW   : hold counter width, MaxHold < 2**HoldW
module req_arbiter16
  import arb_pkg::*;
#(
  parameter int unsigned NReq    = 16,
  parameter int unsigned MaxHold = 12,
  parameter int unsigned HoldW   = 4
) (
  input logic             clk,
  input logic             rst,
  req_arbiter16_if.slave  bus
);

  if (NReq != N_REQ) begin : gen_nreq_chk
    $error("req_arbiter16 supports exactly 16 requesters");
  end
  if (MaxHold >= (1 << HoldW)) begin : gen_hold_chk
    $error("req_arbiter16: MaxHold must be below 2**HoldW");
  end

  localparam bit               TimeoutEn = (MaxHold != 0);
  localparam logic [HoldW-1:0] HoldLast  = HoldW'(MaxHold - 1);

  arb_state_e       state_q, state_d;
  logic [15:0]      grant_q, grant_d;
  logic [3:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [7:0]       status_q, status_d;
  logic             tpulse_q, tpulse_d;
  logic [3:0]       last_q, last_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic [3:0]  rot_amt;
  logic [15:0] req_rot;
  logic [3:0]  enc_idx;
  logic        enc_any;
  logic [3:0]  winner;
  logic        end_release;
  logic        end_withdraw;
  logic        end_timeout;

  // Rotating by last_q puts requester last_q-1 at the top of the search and
  // last_q itself at the bottom; fixed mode searches the raw vector.
  assign rot_amt = bus.rr_mode ? last_q : 4'd0;
  assign req_rot = rot_right16(bus.req, rot_amt);

  prio_enc16 u_prio_enc (
    .in_i  (req_rot),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Undo the rotation (mod 16 wraps naturally in 4 bits).
  assign winner = enc_idx + rot_amt;

  assign end_release  = bus.release_req;
  assign end_withdraw = ~bus.req[idx_q];
  assign end_timeout  = TimeoutEn && (hold_q == HoldLast);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    status_d = status_q;
    tpulse_d = 1'b0;
    last_d   = last_q;
    hold_d   = hold_q;

    unique case (state_q)
      StIdle: begin
        if (enc_any) begin
          state_d  = StBusy;
          grant_d  = 16'(1) << winner;
          idx_d    = winner;
          valid_d  = 1'b1;
          status_d = {4'h0, winner};
          last_d   = winner;
          hold_d   = '0;
        end
      end
      StBusy: begin
        if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
        if (end_release || end_withdraw || end_timeout) begin
          state_d  = StIdle;
          grant_d  = '0;
          valid_d  = 1'b0;
          status_d = NO_GRANT_CODE;
          // A coinciding release or withdrawal takes precedence: no pulse.
          tpulse_d = end_timeout && !end_release && !end_withdraw;
        end
      end
      default: begin
        state_d  = StIdle;
        grant_d  = '0;
        valid_d  = 1'b0;
        status_d = NO_GRANT_CODE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      status_q <= NO_GRANT_CODE;
      tpulse_q <= 1'b0;
      last_q   <= 4'hF;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      status_q <= status_d;
      tpulse_q <= tpulse_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_idx     = idx_q;
  assign bus.grant_valid   = valid_q;
  assign bus.status        = status_q;
  assign bus.timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_req_arbiter16.sv
module tb_req_arbiter16;

  localparam int MAX_HOLD = 12;

  logic clk = 1'b0;
  logic rst;

  req_arbiter16_if bus ();

  req_arbiter16 #(
    .NReq    (16),
    .MaxHold (MAX_HOLD),
    .HoldW   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference winner: walk the requesters in priority order.
  function automatic int pick(input logic [15:0] r, input bit rr, input int last);
    int  w;
    bit  found;
    w = -1;
    found = 1'b0;
    if (!rr) begin
      for (int i = 15; i >= 0; i--) begin
        if (!found && r[i]) begin
          w = i;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= 16; k++) begin
        int c;
        c = (last - k + 32) % 16;
        if (!found && r[c]) begin
          w = c;
          found = 1'b1;
        end
      end
    end
    return w;
  endfunction

  // Behavioural model: grant state plus number of cycles the grant has been shown.
  bit model_on = 1'b0;
  bit m_busy;
  bit m_tp;
  int m_idx;
  int m_last;
  int m_cnt;

  always @(posedge clk) begin
    int w;
    bit wd;
    bit timed_out;
    if (rst) begin
      m_busy   = 1'b0;
      m_tp     = 1'b0;
      m_idx    = 0;
      m_last   = 15;
      m_cnt    = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      m_tp = 1'b0;
      if (!m_busy) begin
        w = pick(bus.req, bus.rr_mode, m_last);
        if (w >= 0) begin
          m_busy = 1'b1;
          m_idx  = w;
          m_last = w;
          m_cnt  = 1;
        end
      end else begin
        wd        = !bus.req[m_idx];
        timed_out = (MAX_HOLD != 0) && (m_cnt == MAX_HOLD);
        if (bus.release_req || wd || timed_out) begin
          m_busy = 1'b0;
          m_tp   = timed_out && !bus.release_req && !wd;
        end else begin
          m_cnt++;
        end
      end
    end
    #1;
    if (model_on) begin
      chk("grant", bus.grant, m_busy ? (32'h1 << m_idx) : 32'h0);
      chk("grant_idx", bus.grant_idx, m_idx);
      chk("grant_valid", bus.grant_valid, m_busy);
      chk("status", bus.status, m_busy ? m_idx : 32'hF0);
      chk("timeout_pulse", bus.timeout_pulse, m_tp);
    end
  end

  int seq [5];
  int exp_seq [5] = '{15, 10, 5, 0, 15};
  int cnt;

  initial begin
    rst             = 1'b1;
    bus.req         = '0;
    bus.rr_mode     = 1'b0;
    bus.release_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset, release in idle ignored.
    bus.release_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_grant", bus.grant, 0);
      chk("idle_status", bus.status, 8'hF0);
      chk("idle_tp", bus.timeout_pulse, 0);
    end
    bus.release_req = 1'b0;

    // Fixed priority.
    bus.req = 16'h8421;
    @(negedge clk);
    chk("fixed_grant", bus.grant, 16'h8000);
    chk("fixed_status", bus.status, 8'h0F);
    repeat (2) @(negedge clk);
    bus.release_req = 1'b1;
    @(negedge clk);
    bus.release_req = 1'b0;
    chk("fixed_bubble", bus.status, 8'hF0);
    @(negedge clk);
    chk("fixed_regrant", bus.grant, 16'h8000);

    // Round-robin, enabled mid-grant, release on the 2nd busy cycle.
    bus.rr_mode = 1'b1;
    for (int g = 0; g < 5; g++) begin
      seq[g] = bus.grant_idx;
      @(negedge clk);
      bus.release_req = 1'b1;
      @(negedge clk);
      bus.release_req = 1'b0;
      chk("rr_bubble", bus.grant_valid, 0);
      if (g < 4) @(negedge clk);
    end
    for (int g = 0; g < 5; g++) chk("rr_seq", seq[g], exp_seq[g]);
    bus.req     = '0;
    bus.rr_mode = 1'b0;
    @(negedge clk);

    // Hold timeout.
    bus.req = 16'h0010;
    @(negedge clk);
    cnt = 0;
    while (bus.grant_valid && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_len", cnt, 12);
    chk("timeout_pulse", bus.timeout_pulse, 1);
    @(negedge clk);
    chk("timeout_regrant", {bus.grant_valid, bus.grant_idx}, {1'b1, 4'd4});
    chk("timeout_pulse_once", bus.timeout_pulse, 0);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Release, withdrawal and timeout all on the same edge.
    bus.req = 16'h0080;
    @(negedge clk);
    chk("coll_idx", bus.grant_idx, 7);
    repeat (11) @(negedge clk);
    bus.req         = '0;
    bus.release_req = 1'b1;
    @(negedge clk);
    bus.release_req = 1'b0;
    chk("coll_valid", bus.grant_valid, 0);
    chk("coll_tp", bus.timeout_pulse, 0);
    @(negedge clk);
    chk("coll_tp2", bus.timeout_pulse, 0);

    // Reset mid-grant restores the round-robin pointer.
    bus.rr_mode = 1'b1;
    bus.req     = 16'h0008;
    @(negedge clk);
    chk("rst_pre_idx", bus.grant_idx, 3);
    rst     = 1'b1;
    bus.req = 16'hFFFF;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_grant", bus.grant, 0);
    chk("rst_tp", bus.timeout_pulse, 0);
    @(negedge clk);
    chk("rst_regrant", bus.grant_idx, 14);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.req = '0;
          1: bus.req = 16'($urandom) & 16'($urandom) & 16'($urandom);
          2: bus.req = 16'h1 << $urandom_range(0, 15);
          default: bus.req = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0) bus.rr_mode = ~bus.rr_mode;
      bus.release_req = ($urandom_range(0, 9) == 0);
      rst             = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/req_arbiter16.md
Name: req_arbiter16

Overview:
- Sequential arbiter that shares one downstream resource between 16 requesters.
- Built around a highest-index-first priority encoder.
- Registers the winner and holds the grant until release, requester withdrawal or hold timeout.
- Exports a one-hot grant, a 4-bit index and an 8-bit status code (0xF0 = no grant) for the top-level uo_out mux.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16, and any other value is a synthesis error.
- MAX_HOLD, 12, maximum consecutive grant cycles before forced revoke; 0 disables the timeout.
- HOLD_W, 4, width of the hold counter; must satisfy MAX_HOLD < 2**HOLD_W.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- req  in  16  request vector; bit i = requester i.
- rr_mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin. Sampled only in IDLE.
- release  in  1  current grantee is done; meaningful only in BUSY.
- grant  out  16  one-hot grant, or all-zero.
- grant_idx  out  4  index of the current grantee; holds its last value when no grant.
- grant_valid  out  1  a grant is active.
- status  out  8  {4'b0000, grant_idx} when grant_valid, else 8'hF0.
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst); it is sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, grant=0, grant_idx=0, grant_valid=0, status=8'hF0, timeout_pulse=0.
  - Round-robin pointer last_idx=4'hF, hold_cnt=0.
- All outputs are registered; there is no combinational path from req to grant.
- IDLE:
  - Entry: if req==0, remain in IDLE.
  - Winner selection (fixed mode): the highest set bit of req.
  - Winner selection (RR mode): req is rotated so the search starts at last_idx-1 (mod 16) and proceeds downward cyclically. The first set bit wins, so the last grantee has the lowest priority.
  - Exit: load grant/grant_idx, set last_idx=winner, hold_cnt=0, go to BUSY.
  - Latency: req asserted at edge t gives grant_valid=1 after edge t+1.
- BUSY:
  - Each cycle: hold_cnt increments, saturating at 2**HOLD_W-1.
  - End conditions, in priority order:
    - (a) release=1;
    - (b) req[grant_idx]=0 (requester withdrew);
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - Only (c) alone sets timeout_pulse on the next edge; if (a) or (b) coincides with (c), no pulse.
  - On any end condition: next edge clears grant/grant_valid, status=8'hF0, go to IDLE.
  - Bubble: exactly one idle cycle between consecutive grants. Re-arbitration happens in IDLE with the updated last_idx.
  - Grant length: a grant lasts at most MAX_HOLD cycles.
- Simultaneous events:
  - New requests arriving during BUSY do not pre-empt the current grantee.
  - A request that drops in IDLE on the same edge it would win is not granted, because arbitration uses the sampled req.
  - rr_mode changes during BUSY take effect at the next IDLE arbitration.
- Wrap-around: last_idx=0 means the RR search starts at 15. last_idx=4'hF after reset means the RR search starts at 14, and index 15 has lowest priority for the first grant.
- Reset mid-operation: rst in any state clears the grant on that edge. No timeout_pulse is generated, and last_idx returns to 4'hF.
- release asserted in IDLE is ignored.

Decomposition:
- Shared package arb_pkg holds:
  - State enum {IDLE, BUSY};
  - constant NO_GRANT_CODE = 8'hF0;
  - constant N_REQ = 16;
  - function rot_right16(vec, amt).
- Sub-module prio_enc16: purely combinational. Input in[15:0]; outputs idx[3:0] and any. Reports the highest set bit.
- Winner mapping: the arbiter instantiates one prio_enc16 on the rotated vector and maps the index back modulo 16. Fixed mode uses rotation amount 0.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then req=0 -> grant=0, status=8'hF0 for 10 cycles; timeout_pulse never set.
- Fixed priority: rr_mode=0, req=16'h8421 held -> one edge later grant=16'h8000, status=8'h0F. Release at cycle 3 -> one idle cycle with status=8'hF0, then grant=16'h8000 again.
- Round-robin fairness: rr_mode=1, req=16'h8421 held, release every 2nd BUSY cycle -> grant_idx sequence 15,10,5,0,15 with one bubble between grants.
- Timeout: MAX_HOLD=12, req=16'h0010 held, no release -> grant_valid for exactly 12 cycles, timeout_pulse=1 for one cycle after revoke, regrant idx 4 after a one-cycle bubble.
- Withdrawal and collision: grantee idx 7 drops req on the same cycle release=1 and hold_cnt==MAX_HOLD-1 -> grant cleared next edge, timeout_pulse stays 0.
- Reset mid-grant: rr_mode=1, idx 3 granted, assert rst for one cycle with req=16'hFFFF held -> grant=0 on that edge, then grant_idx=14 (pointer restored to 15).
